alignment_scheduler: RTL and testbench

- Row-major sequencer that time-shares one cell-scoring processing unit across the full (N+1)x(M+1) global-alignment score matrix.
- Owns the previous-row score buffer, the boundary values (k*gap), the diagonal and left operand registers, and the request/acknowledge handshake to the PE.
- Reports the bottom-right cell score as the alignment result.
- Sits between the top-level start/done control and a single processing unit instance.

---
 rtl/alignment_scheduler.sv | 158 +++++++++++++++
 tb/tb_alignment_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alignment_scheduler.sv
// Row-major sequencer for a global-alignment score matrix: fills the (N+1)x(M+1)
// matrix one cell at a time through a single shared scoring PE.
module alignment_scheduler #(
  parameter int N  = 29,
  parameter int M  = 29,
  parameter int IW = $clog2(N + 1),
  parameter int JW = $clog2(M + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [31:0]   gap_penalty,
  output logic                 pe_req,
  output logic [IW-1:0]        pe_i,
  output logic [JW-1:0]        pe_j,
  output logic signed [31:0]   pe_diag,
  output logic signed [31:0]   pe_vert,
  output logic signed [31:0]   pe_horiz,
  input  logic                 pe_ack,
  input  logic signed [31:0]   pe_score,
  output logic                 busy,
  output logic                 done,
  output logic signed [31:0]   final_score,
  output logic [IW+JW-1:0]     cells_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [IW-1:0] I_LAST = IW'(N);
  localparam logic [JW-1:0] J_LAST = JW'(M);

  state_t state, state_nxt;

  logic signed [31:0] row [0:M];
  logic signed [31:0] gap, acc, bnd, diag, left, final_q;
  logic [IW-1:0]      i;
  logic [JW-1:0]      j, k;
  logic [IW+JW-1:0]   cnt;
  logic               ack;
  logic               row_end, last_cell;

  assign ack       = (state == S_WAIT) && pe_ack;
  assign row_end   = (j == J_LAST);
  assign last_cell = row_end && (i == I_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_INIT;
      S_INIT:  if (k == J_LAST) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (pe_ack) state_nxt = last_cell ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sequencing registers; the row wrap folds into the last ack of a row so it costs no cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap     <= '0;
      acc     <= '0;
      bnd     <= '0;
      diag    <= '0;
      left    <= '0;
      final_q <= '0;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            gap     <= gap_penalty;
            k       <= '0;
            acc     <= '0;
            cnt     <= '0;
            final_q <= '0;
          end
        end
        S_INIT: begin
          acc <= acc + gap;
          k   <= k + JW'(1);
          if (k == J_LAST) begin
            i    <= IW'(1);
            j    <= JW'(1);
            diag <= '0;
            left <= gap;
            bnd  <= gap;
          end
        end
        S_WAIT: begin
          if (pe_ack) begin
            cnt  <= cnt + (IW+JW)'(1);
            diag <= row[j];
            left <= pe_score;
            if (!row_end) begin
              j <= j + JW'(1);
            end else if (i != I_LAST) begin
              i    <= i + IW'(1);
              j    <= JW'(1);
              diag <= row[0];
              bnd  <= bnd + gap;
              left <= bnd + gap;
            end else begin
              final_q <= pe_score;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Previous-row buffer: row[0] carries the left boundary of the current row.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      row[k] <= acc;
      if (k == J_LAST) row[0] <= gap;
    end else if (ack) begin
      row[j] <= pe_score;
      if (row_end && (i != I_LAST)) row[0] <= bnd + gap;
    end
  end

  always_comb begin
    pe_req      = (state == S_ISSUE);
    pe_i        = '0;
    pe_j        = '0;
    pe_diag     = '0;
    pe_vert     = '0;
    pe_horiz    = '0;
    if (state == S_ISSUE) begin
      pe_i     = i;
      pe_j     = j;
      pe_diag  = diag;
      pe_vert  = row[j];
      pe_horiz = left;
    end
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    final_score = final_q;
    cells_done  = cnt;
  end

endmodule

// File: tb/tb_alignment_scheduler.sv
// Scoreboard bench for alignment_scheduler: a behavioural scoring PE answers each request,
// expected operands and completions are queued by the stimulus and popped by monitors.
module tb_alignment_scheduler;

  typedef struct {
    int i;
    int j;
    int d;
    int v;
    int h;
  } req_t;

  typedef struct {
    int score;
    int cells;
    int lat;
  } done_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: 2x2 matrix
  logic               start_a;
  logic signed [31:0] gap_a;
  logic               pe_req_a, pe_ack_a, busy_a, done_a;
  logic [1:0]         pe_i_a, pe_j_a;
  logic signed [31:0] pe_diag_a, pe_vert_a, pe_horiz_a, pe_score_a, final_a;
  logic [3:0]         cells_a;

  // DUT B: 3x1 matrix
  logic               start_b;
  logic signed [31:0] gap_b;
  logic               pe_req_b, pe_ack_b, busy_b, done_b;
  logic [1:0]         pe_i_b;
  logic [0:0]         pe_j_b;
  logic signed [31:0] pe_diag_b, pe_vert_b, pe_horiz_b, pe_score_b, final_b;
  logic [2:0]         cells_b;

  alignment_scheduler #(.N(2), .M(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .gap_penalty(gap_a),
    .pe_req(pe_req_a), .pe_i(pe_i_a), .pe_j(pe_j_a),
    .pe_diag(pe_diag_a), .pe_vert(pe_vert_a), .pe_horiz(pe_horiz_a),
    .pe_ack(pe_ack_a), .pe_score(pe_score_a),
    .busy(busy_a), .done(done_a), .final_score(final_a), .cells_done(cells_a)
  );

  alignment_scheduler #(.N(3), .M(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .gap_penalty(gap_b),
    .pe_req(pe_req_b), .pe_i(pe_i_b), .pe_j(pe_j_b),
    .pe_diag(pe_diag_b), .pe_vert(pe_vert_b), .pe_horiz(pe_horiz_b),
    .pe_ack(pe_ack_b), .pe_score(pe_score_b),
    .busy(busy_b), .done(done_b), .final_score(final_b), .cells_done(cells_b)
  );

  req_t  exp_req_a[$];
  done_t exp_done_a[$];
  req_t  exp_req_b[$];
  done_t exp_done_b[$];
  int    t0_a = 0, t0_b = 0;
  int    lat_a = 1;
  bit    stray_a = 1'b0;
  string sa = "AC";
  string sb = "AC";

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Needleman-Wunsch cell: match +1, mismatch -1, 32-bit wrapping sums.
  function automatic logic signed [31:0] pe_fn(input int i, input int j,
      input logic signed [31:0] d, input logic signed [31:0] v,
      input logic signed [31:0] h, input logic signed [31:0] g);
    logic signed [31:0] sd, sv, sh, m;
    sd = d + ((sa[i-1] == sb[j-1]) ? 32'sd1 : -32'sd1);
    sv = v + g;
    sh = h + g;
    m = sd;
    if (sv > m) m = sv;
    if (sh > m) m = sh;
    return m;
  endfunction

  // PE for A: configurable latency; optional stray acks outside WAIT.
  initial begin : pe_a
    logic signed [31:0] s;
    pe_ack_a = 1'b0;
    pe_score_a = '0;
    forever begin
      if (pe_req_a === 1'b1) begin
        s = pe_fn(int'(pe_i_a), int'(pe_j_a), pe_diag_a, pe_vert_a, pe_horiz_a, gap_a);
        if (stray_a) begin
          pe_ack_a = 1'b1;
          pe_score_a = 32'sd999;
        end
        repeat (lat_a) begin
          @(posedge clk); #1;
          pe_ack_a = 1'b0;
        end
        pe_ack_a = 1'b1;
        pe_score_a = s;
        @(posedge clk); #1;
        pe_ack_a = 1'b0;
      end else begin
        pe_ack_a = stray_a && (busy_a === 1'b1);
        pe_score_a = 32'sd777;
        @(posedge clk); #1;
        pe_ack_a = 1'b0;
      end
    end
  end

  // PE for B: 1-cycle latency, score = 5*i.
  initial begin : pe_b
    logic signed [31:0] s;
    pe_ack_b = 1'b0;
    pe_score_b = '0;
    forever begin
      if (pe_req_b === 1'b1) begin
        s = 5 * int'(pe_i_b);
        @(posedge clk); #1;
        pe_ack_b = 1'b1;
        pe_score_b = s;
        @(posedge clk); #1;
        pe_ack_b = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  always @(negedge clk) begin : mon_a
    req_t  e;
    done_t dn;
    if (pe_req_a === 1'b1) begin
      if (exp_req_a.size() == 0) chk("reqA_unexpected", 1, 0);
      else begin
        e = exp_req_a.pop_front();
        chk("reqA_i", int'(pe_i_a), e.i);
        chk("reqA_j", int'(pe_j_a), e.j);
        chk("reqA_diag", pe_diag_a, e.d);
        chk("reqA_vert", pe_vert_a, e.v);
        chk("reqA_horiz", pe_horiz_a, e.h);
      end
    end
    if (done_a === 1'b1) begin
      if (exp_done_a.size() == 0) chk("doneA_unexpected", 1, 0);
      else begin
        dn = exp_done_a.pop_front();
        chk("doneA_score", final_a, dn.score);
        chk("doneA_cells", int'(cells_a), dn.cells);
        chk("doneA_cycle", cyc - t0_a, dn.lat);
        chk("doneA_busy", int'(busy_a), 1);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    req_t  e;
    done_t dn;
    if (pe_req_b === 1'b1) begin
      if (exp_req_b.size() == 0) chk("reqB_unexpected", 1, 0);
      else begin
        e = exp_req_b.pop_front();
        chk("reqB_i", int'(pe_i_b), e.i);
        chk("reqB_j", int'(pe_j_b), e.j);
        chk("reqB_diag", pe_diag_b, e.d);
        chk("reqB_vert", pe_vert_b, e.v);
        chk("reqB_horiz", pe_horiz_b, e.h);
      end
    end
    if (done_b === 1'b1) begin
      if (exp_done_b.size() == 0) chk("doneB_unexpected", 1, 0);
      else begin
        dn = exp_done_b.pop_front();
        chk("doneB_score", final_b, dn.score);
        chk("doneB_cells", int'(cells_b), dn.cells);
        chk("doneB_cycle", cyc - t0_b, dn.lat);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // A="AC", B="AC", gap=-2: cells 1,-1,-1,2
  task automatic push_ac(input int lat);
    exp_req_a.push_back('{1, 1,  0, -2, -2});
    exp_req_a.push_back('{1, 2, -2, -4,  1});
    exp_req_a.push_back('{2, 1, -2,  1, -4});
    exp_req_a.push_back('{2, 2,  1, -1, -1});
    exp_done_a.push_back('{2, 4, lat});
  endtask

  task automatic start_run_a(input logic signed [31:0] g, input int lat, input bit stray);
    gap_a = g;
    lat_a = lat;
    stray_a = stray;
    start_a = 1'b1;
    t0_a = cyc;
    step();
    start_a = 1'b0;
  endtask

  task automatic drain_a(input string tag);
    int n = 0;
    while (exp_done_a.size() != 0 && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_req_left"}, exp_req_a.size(), 0);
    chk({tag, "_done_left"}, exp_done_a.size(), 0);
    step();
  endtask

  task automatic drain_b(input string tag);
    int n = 0;
    while (exp_done_b.size() != 0 && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_req_left"}, exp_req_b.size(), 0);
    chk({tag, "_done_left"}, exp_done_b.size(), 0);
    step();
  endtask

  initial begin : stim
    int g, p;
    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    gap_a = '0;
    gap_b = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    chk("rst_pe_req", int'(pe_req_a), 0);
    chk("rst_pe_i", int'(pe_i_a), 0);
    chk("rst_pe_j", int'(pe_j_a), 0);
    chk("rst_pe_diag", pe_diag_a, 0);
    chk("rst_pe_vert", pe_vert_a, 0);
    chk("rst_pe_horiz", pe_horiz_a, 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_final", final_a, 0);
    chk("rst_cells", int'(cells_a), 0);

    // 1-cycle PE
    push_ac(12);
    start_run_a(-32'sd2, 1, 1'b0);
    chk("t1_busy_after_start", int'(busy_a), 1);
    drain_a("t1");

    // 3-cycle PE
    push_ac(20);
    start_run_a(-32'sd2, 3, 1'b0);
    drain_a("t2");

    // stray acks in INIT/ISSUE/DONE and start re-pulsed mid-run
    push_ac(12);
    start_run_a(-32'sd2, 1, 1'b1);
    repeat (4) step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    drain_a("t3");
    stray_a = 1'b0;
    repeat (6) step();
    chk("t3_idle_busy", int'(busy_a), 0);

    // reset during WAIT of cell (2,1)
    exp_req_a.push_back('{1, 1,  0, -2, -2});
    exp_req_a.push_back('{1, 2, -2, -4,  1});
    exp_req_a.push_back('{2, 1, -2,  1, -4});
    start_run_a(-32'sd2, 1, 1'b0);
    repeat (8) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t4_busy", int'(busy_a), 0);
    chk("t4_pe_req", int'(pe_req_a), 0);
    chk("t4_final", final_a, 0);
    chk("t4_cells", int'(cells_a), 0);
    chk("t4_req_left", exp_req_a.size(), 0);
    repeat (3) step();
    chk("t4_still_idle", int'(busy_a), 0);
    push_ac(12);
    start_run_a(-32'sd2, 1, 1'b0);
    drain_a("t4b");

    // boundaries on a 3x1 matrix, gap=-3
    exp_req_b.push_back('{1, 1,  0, -3, -3});
    exp_req_b.push_back('{2, 1, -3,  5, -6});
    exp_req_b.push_back('{3, 1, -6, 10, -9});
    exp_done_b.push_back('{15, 3, 9});
    gap_b = -32'sd3;
    start_b = 1'b1;
    t0_b = cyc;
    step();
    start_b = 1'b0;
    drain_b("t5");

    // wrapping boundaries: 2*gap wraps to 2
    g = 32'h80000001;
    p = 32'h80000003;
    exp_req_a.push_back('{1, 1, 0, g, g});
    exp_req_a.push_back('{1, 2, g, 2, 2});
    exp_req_a.push_back('{2, 1, g, 2, 2});
    exp_req_a.push_back('{2, 2, 2, p, p});
    exp_done_a.push_back('{4, 4, 12});
    start_run_a(32'sh80000001, 1, 1'b0);
    drain_a("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
